bubble_sort_ctrl: RTL
=====================

// Module: bubble_sort_ctrl
// PURPOSE
//  Sequencer driving the dual-port RAM of the sort datapath: in-place ascending bubble sort of RAM[0..len-1].
//  Each compare uses both combinational read ports (addr j, j+1); a swap uses the single write port over two cycles.
//  Sits directly upstream of the RAM; RAM read data returns to it combinationally.
// PARAMETERS
//  ADDR_WIDTH  12  RAM address width; max sortable length 2**ADDR_WIDTH
//  DATA_WIDTH  8   element width; compared as unsigned
// PORTS
//  clk          in   1             rising-edge clock
//  rst          in   1             synchronous, active-high reset
//  start        in   1             1-cycle request; sampled only in IDLE
//  len          in   ADDR_WIDTH+1  element count; captured on accepted start
//  busy         out  1             high from the cycle after accepted start until done
//  done         out  1             1-cycle pulse when sort complete
//  we           out  1             RAM write enable
//  read_addr_1  out  ADDR_WIDTH    RAM port 1 address (= j)
//  read_addr_2  out  ADDR_WIDTH    RAM port 2 address (= j+1)
//  write_addr   out  ADDR_WIDTH    RAM write address
//  write_data   out  DATA_WIDTH    RAM write data
//  read_data_1  in   DATA_WIDTH    RAM[read_addr_1], combinational
//  read_data_2  in   DATA_WIDTH    RAM[read_addr_2], combinational
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, we=0, all addresses 0, write_data 0; pass/index counters 0.
//  States: IDLE -> CMP -> (WR_LO -> WR_HI ->) ADV -> CMP | FIN -> IDLE.
//  IDLE: start=1: latch len; len<2 -> FIN directly (no RAM access); else pass=0, j=0 -> CMP.
//  CMP: addrs j, j+1 driven; latch a=read_data_1, b=read_data_2. a>b -> WR_LO; else -> ADV. Equal: no swap (stable).
//  WR_LO: we=1, write_addr=j, write_data=b.  WR_HI: we=1, write_addr=j+1, write_data=a; set swapped flag.
//  ADV: if j+1 < len-1-pass: j++ -> CMP; else end of pass: pass++, j=0, clear swapped;
//       pass == len-2 (last pass just done) -> FIN; else -> CMP.
//  FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
//  Latency per compare: 2 cycles no swap (CMP,ADV), 4 cycles with swap. we never high outside WR_LO/WR_HI.
//  start while busy: ignored. start in FIN cycle: ignored (accepted next cycle in IDLE).
//  len > 2**ADDR_WIDTH: clamp to 2**ADDR_WIDTH. j+1 never exceeds len-1; no address wrap.
//  rst mid-sort: IDLE next cycle, we=0 immediately; RAM left partially sorted, no further writes.
//  Counters ADDR_WIDTH+1 bits wide; comparisons done at that width.
// CONFIGURATION
//  EARLY_EXIT_EN defined: at end of a pass with swapped=0 -> FIN immediately (sorted input: one pass, len-1 compares).
//  Not defined: always executes len-1 passes regardless of swaps; swapped flag may be optimised away.
//  Final RAM contents identical in both builds; only cycle count differs.
// STRUCTURE
//  Shared header bs_defs.vh: state encodings (S_IDLE, S_CMP, S_WR_LO, S_WR_HI, S_ADV, S_FIN), default widths.
//  Sub-module bs_cmp_swap: registers a/b, outputs gt = (a>b), lo=min, hi=max; controller owns FSM and counters.
// TESTING
//  Bench instantiates controller + dual-port RAM, preloads RAM, checks contents and cycle counts.
//  1) RAM[0..3]={4,3,2,1}, len=4, start -> RAM {1,2,3,4}; 6 compares, 6 swaps; done pulse 1 cycle, busy low after.
//  2) RAM {1,2,3,4}, len=4 -> unchanged, we never asserted; EARLY_EXIT_EN: done after 3 compares, else after 6.
//  3) len=0 and len=1 -> done 2 cycles after start, no RAM reads affecting state, no writes.
//  4) RAM {5,5,0,255,5}, len=5 -> {0,5,5,5,255}; equal pairs never written (monitor we/write_addr).
//  5) start pulsed again while busy -> ignored; rst asserted during WR_LO -> we=0 next edge, busy=0, no done.
//  6) ADDR_WIDTH=3, len=8 reverse {7..0} -> {0..7}, addresses stay within 0..7; len=9 clamped to 8.

Source files
------------

// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared definitions for the bubble-sort RAM sequencer: default widths and
// the controller state encoding.
package bubble_sort_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMP   = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_ADV   = 3'd4,
    S_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/bubble_sort_ctrl_cmp_swap.sv
// Compare/swap operand holder for the bubble-sort sequencer.
// Captures the two RAM read words on load. gt is evaluated on the operands
// being captured, so the controller can branch in the same cycle. lo/hi give
// min/max of the held pair and are used as the write-back data.
module bubble_sort_ctrl_cmp_swap
  import bubble_sort_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] rd_1,
  input  logic [DATA_WIDTH-1:0] rd_2,
  output logic                  gt,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;

  // Next operand values: capture on load, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    a_d = a_q;
    b_d = b_q;
    if (load) begin
      a_d = rd_1;
      b_d = rd_2;
    end
  end

  // Operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Unsigned compare of incoming pair; min/max of held pair.
  always_comb begin
    gt = (rd_1 > rd_2);
    lo = (a_q > b_q) ? b_q : a_q;
    hi = (a_q > b_q) ? a_q : b_q;
  end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer for a dual-port RAM (two combinational read ports,
// one write port). Sorts RAM[0..len-1] ascending, in place, unsigned.
// Optional macro EARLY_EXIT_EN: finish as soon as a pass makes no swap.
// Without it, len-1 passes always run; the final RAM contents are the same.
module bubble_sort_ctrl
  import bubble_sort_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);
  localparam logic [CW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   pass_q, pass_d;
  logic [CW-1:0]   j_q, j_d;
`ifdef EARLY_EXIT_EN
  logic            swapped_q, swapped_d;
`endif

  logic [CW-1:0]   len_clamped;
  logic [CW-1:0]   j_inc;
  logic [CW-1:0]   pass_limit;
  logic            gt;
  logic [DATA_WIDTH-1:0] lo, hi;

  // Operand capture happens in CMP; the swap data comes back as min/max.
  bubble_sort_ctrl_cmp_swap #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp_swap (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == S_CMP),
    .rd_1 (read_data_1),
    .rd_2 (read_data_2),
    .gt   (gt),
    .lo   (lo),
    .hi   (hi)
  );

  // Length clamp and loop-bound arithmetic, all at counter width.
  always_comb begin
    len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    j_inc       = j_q + ONE;
    pass_limit  = len_q - ONE - pass_q;
  end

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pass_d    = pass_q;
    j_d       = j_q;
`ifdef EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = len_clamped;
          pass_d = '0;
          j_d    = '0;
`ifdef EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          state_d = (len_clamped < TWO) ? S_FIN : S_CMP;
        end
      end
      S_CMP:   state_d = gt ? S_WR_LO : S_ADV;
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: begin
`ifdef EARLY_EXIT_EN
        swapped_d = 1'b1;
`endif
        state_d = S_ADV;
      end
      S_ADV: begin
        if (j_inc < pass_limit) begin
          j_d     = j_inc;
          state_d = S_CMP;
        end else begin
          pass_d = pass_q + ONE;
          j_d    = '0;
`ifdef EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          if (pass_q == len_q - TWO) begin
            state_d = S_FIN;
`ifdef EARLY_EXIT_EN
          end else if (!swapped_q) begin
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_CMP;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      pass_q    <= '0;
      j_q       <= '0;
`ifdef EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pass_q    <= pass_d;
      j_q       <= j_d;
`ifdef EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  // RAM-side outputs decoded from the registered state; idle values are zero.
  always_comb begin
    busy        = (state_q == S_CMP) || (state_q == S_WR_LO) ||
                  (state_q == S_WR_HI) || (state_q == S_ADV);
    done        = (state_q == S_FIN);
    we          = 1'b0;
    read_addr_1 = '0;
    read_addr_2 = '0;
    write_addr  = '0;
    write_data  = '0;
    case (state_q)
      S_CMP: begin
        read_addr_1 = j_q[ADDR_WIDTH-1:0];
        read_addr_2 = j_inc[ADDR_WIDTH-1:0];
      end
      S_WR_LO: begin
        we         = 1'b1;
        write_addr = j_q[ADDR_WIDTH-1:0];
        write_data = lo;
      end
      S_WR_HI: begin
        we         = 1'b1;
        write_addr = j_inc[ADDR_WIDTH-1:0];
        write_data = hi;
      end
      default: ;
    endcase
  end

endmodule
